// File: rtl/clksel_fsm_pkg.sv
// Shared types and constants for the CPU clock-select controller: FSM state
// encoding, slow IO window bounds and config register layout.
package clksel_fsm_pkg;

   typedef enum logic [1:0] {
      ST_SLOW    = 2'd0,
      ST_TO_FAST = 2'd1,
      ST_FAST    = 2'd2,
      ST_TO_SLOW = 2'd3
   } state_e;

   localparam logic [7:0] IO_PAGE_LO = 8'hFC;
   localparam logic [7:0] IO_PAGE_HI = 8'hFE;
   localparam logic [7:0] BOOT_BANK  = 8'hFF;

   localparam int CFG_W          = 3;
   localparam int CFG_DIV_LSB    = 0;
   localparam int CFG_DIV_MSB    = 1;
   localparam int CFG_SHADOW_BIT = 2;

   // With shadowing off the whole boot bank is slow; with it on only the IO pages are.
   function automatic logic is_slow_access(input logic [15:0] bank_page,
                                           input logic        vda,
                                           input logic        vpa,
                                           input logic        shadow_en);
      logic in_io;
      in_io = (bank_page[7:0] >= IO_PAGE_LO) && (bank_page[7:0] <= IO_PAGE_HI);
      return (vda || vpa) && (bank_page[15:8] == BOOT_BANK) && (in_io || !shadow_en);
   endfunction

endpackage

// File: rtl/clksel_fsm_sync.sv
// Multi-flop synchronizer for one asynchronous status bit.
module sync_bit
   import clksel_fsm_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);
   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clksel_fsm.sv
// Clock-select FSM: runs the CPU on the high-speed clock and drops to the slow
// clock (with a programmable divider) for accesses into the slow boot-bank window.
module clksel_fsm
   import clksel_fsm_pkg::*;
#(
   parameter int HOLD_CYCLES = 2,
   parameter int TIMEOUT     = 255,
   parameter int SYNC_STAGES = 2
) (
   input  logic             hsclk_in,
   input  logic             rst,
   input  logic             addr_valid,
   input  logic [23:0]      cpu_addr,
   input  logic             cpu_vda,
   input  logic             cpu_vpa,
   input  logic             cfg_wr,
   input  logic [CFG_W-1:0] cfg_wdata,
   input  logic             hsclk_selected,
   input  logic             lsclk_selected,
   output logic             hsclk_sel,
   output logic [1:0]       cpuclk_div_sel,
   output logic             busy,
   output logic             err,
   output logic [1:0]       dbg_state_o,
   output logic [7:0]       dbg_hold_o
);
   localparam logic [7:0] HOLD_MAX = 8'(HOLD_CYCLES);
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [7:0]       hold_q, hold_d, hold_inc;
   logic [7:0]       tmo_q, tmo_d;
   logic [CFG_W-1:0] cfg_q, cfg_d;
   logic [1:0]       div_q, div_d;
   logic             hs_sel_q, hs_sel_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic             hs_ack, ls_ack;
   logic             slow_req, fast_elig;
   logic             unused_addr_lo;

   sync_bit #(.STAGES(SYNC_STAGES)) u_sync_hs (
      .clk_i (hsclk_in),
      .rst_i (rst),
      .d_i   (hsclk_selected),
      .q_o   (hs_ack)
   );

   sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ls (
      .clk_i (hsclk_in),
      .rst_i (rst),
      .d_i   (lsclk_selected),
      .q_o   (ls_ack)
   );

   // Decode sees cfg_q, so a config write in the same cycle only affects later accesses.
   assign slow_req  = addr_valid &&
                      is_slow_access(cpu_addr[23:8], cpu_vda, cpu_vpa, cfg_q[CFG_SHADOW_BIT]);
   assign fast_elig = addr_valid && !slow_req;
   assign hold_inc  = (hold_q >= HOLD_MAX) ? HOLD_MAX : hold_q + 8'd1;
   assign unused_addr_lo = ^cpu_addr[7:0];

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      hs_sel_d = hs_sel_q;
      err_d    = err_q;
      case (state_q)
         ST_SLOW: begin
            if (slow_req) begin
               hold_d = '0;
            end else if (fast_elig) begin
               hold_d = hold_inc;
               if (hold_inc == HOLD_MAX) begin
                  state_d  = ST_TO_FAST;
                  hs_sel_d = 1'b1;
               end
            end
         end
         ST_TO_FAST: begin
            if (slow_req) begin
               state_d  = ST_TO_SLOW;
               hs_sel_d = 1'b0;
            end else if (hs_ack && !ls_ack) begin
               state_d = ST_FAST;
            end else if (tmo_q == TMO_LAST) begin
               state_d  = ST_SLOW;
               hs_sel_d = 1'b0;
               err_d    = 1'b1;
            end
         end
         ST_FAST: begin
            if (slow_req) begin
               state_d  = ST_TO_SLOW;
               hs_sel_d = 1'b0;
            end
         end
         ST_TO_SLOW: begin
            // Fast-eligible accesses are deliberately ignored until the slow clock is confirmed.
            if (ls_ack && !hs_ack) begin
               state_d = ST_SLOW;
            end else if (tmo_q == TMO_LAST) begin
               state_d = ST_SLOW;
               err_d   = 1'b1;
            end
         end
         default: begin
            state_d  = ST_SLOW;
            hs_sel_d = 1'b0;
         end
      endcase

      if (state_d == ST_SLOW && state_q != ST_SLOW) begin
         hold_d = '0;
      end

      if (state_d != state_q) begin
         tmo_d = '0;
      end else if (state_q == ST_TO_FAST || state_q == ST_TO_SLOW) begin
         tmo_d = tmo_q + 8'd1;
      end else begin
         tmo_d = '0;
      end

      busy_d = (state_d == ST_TO_FAST) || (state_d == ST_TO_SLOW);
      cfg_d  = cfg_wr ? cfg_wdata : cfg_q;
      // The divider only follows the config while the slow clock is the one in use.
      div_d  = (state_q == ST_SLOW) ? cfg_q[CFG_DIV_MSB:CFG_DIV_LSB] : div_q;
   end

   always_ff @(posedge hsclk_in or posedge rst) begin
      if (rst) begin
         state_q  <= ST_SLOW;
         hold_q   <= '0;
         tmo_q    <= '0;
         cfg_q    <= '0;
         div_q    <= '0;
         hs_sel_q <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         tmo_q    <= tmo_d;
         cfg_q    <= cfg_d;
         div_q    <= div_d;
         hs_sel_q <= hs_sel_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
      end
   end

   assign hsclk_sel      = hs_sel_q;
   assign cpuclk_div_sel = div_q;
   assign busy           = busy_q;
   assign err            = err_q;
   assign dbg_state_o    = state_q;
   assign dbg_hold_o     = hold_q;

endmodule

// File: doc/clksel_fsm.md
CLKSEL_FSM -- requirements
Module: clksel_fsm

Interface
REQ-001 Parameter HOLD_CYCLES, default 2: consecutive fast-eligible accesses in SLOW before a switch back to FAST.
REQ-002 Parameter TIMEOUT, default 255: hsclk_in cycles to wait for switch acknowledge before error.
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer depth on acknowledge inputs.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 Port hsclk_in, input, 1: sole clock, rising edge.
REQ-006 Port rst, input, 1: asynchronous active-high reset.
REQ-007 Port addr_valid, input, 1: one-cycle strobe marking a stable CPU address.
REQ-008 Port cpu_addr, input, 24: 65816 bank:address.
REQ-009 Port cpu_vda and cpu_vpa, input, 1 each: valid data / program address qualifiers.
REQ-010 Port cfg_wr, input, 1: config register write strobe.
REQ-011 Port cfg_wdata, input, 3: [1:0] requested divider select, [2] shadow enable.
REQ-012 Port hsclk_selected and lsclk_selected, input, 1 each: clock-controller status, asynchronous to hsclk_in.
REQ-013 Port hsclk_sel, output, 1: request for the high-speed clock.
REQ-014 Port cpuclk_div_sel, output, 2: divider select presented to the clock controller.
REQ-015 Port busy, output, 1: a switch is in progress.
REQ-016 Port err, output, 1: sticky switch-timeout flag.

Function
REQ-017 Acknowledge inputs SHALL each pass through SYNC_STAGES flops; only synchronized values (ls_ack, hs_ack) are used.
REQ-018 slow_req SHALL be asserted when addr_valid & (cpu_vda|cpu_vpa) & cpu_addr[23:16]==8'hFF & (cpu_addr[15:8] in 8'hFC..8'hFE, or shadow enable==0).
REQ-019 An access with addr_valid=1 and slow_req=0 is fast-eligible.
REQ-020 The FSM SHALL have states SLOW, TO_FAST, FAST, TO_SLOW, all registered.
REQ-021 FAST: slow_req moves to TO_SLOW next cycle; hsclk_sel=0 from that same edge.
REQ-022 TO_SLOW: go to SLOW when ls_ack=1 and hs_ack=0.
REQ-023 SLOW: 8-bit hold counter increments per fast-eligible access, clears on slow_req; at HOLD_CYCLES, go to TO_FAST with hsclk_sel=1 from that edge.
REQ-024 TO_FAST: go to FAST when hs_ack=1 and ls_ack=0.
REQ-025 busy SHALL be 1 exactly in TO_SLOW and TO_FAST.
REQ-026 slow_req arriving during TO_FAST SHALL abort: next state TO_SLOW, hsclk_sel=0.
REQ-027 Fast-eligible accesses during TO_SLOW SHALL be ignored; the switch always completes.
REQ-028 An 8-bit timeout counter runs in TO_* states and clears on every state change; on reaching TIMEOUT, err=1, hsclk_sel=0, next state SLOW.
REQ-029 err SHALL be cleared only by reset.
REQ-030 cfg_wr SHALL latch cfg_wdata into the config register on the next edge in any state.
REQ-031 Decode in a cycle with simultaneous cfg_wr and addr_valid SHALL use the old config value.
REQ-032 cpuclk_div_sel SHALL copy the config divider field only while in SLOW, so the divider never changes while the high-speed clock is running.
REQ-033 A divider written in FAST or TO_* SHALL appear one cycle after the next SLOW entry.
REQ-034 The hold counter SHALL saturate at HOLD_CYCLES and never wrap.

Reset
REQ-035 On rst: state SLOW, hsclk_sel=0, busy=0, err=0.
REQ-036 On rst: cpuclk_div_sel=2'b00, config register=3'b000, both counters and synchronizers 0.
REQ-037 Reset asserted mid-switch SHALL abandon the switch immediately; no pending divider update survives.

Structure
REQ-038 A shared package SHALL hold the state enum, IO page bounds (8'hFC, 8'hFE), boot bank 8'hFF and config field positions.
REQ-039 The synchronizer SHALL be a sub-module named sync_bit, instanced twice.

Verification
REQ-040 Reset, then 2 fast accesses at 24'h001000 with hs_ack modeled after 3 cycles -> TO_FAST then FAST; hsclk_sel=1; busy high 3+SYNC_STAGES cycles.
REQ-041 In FAST, access at 24'hFFFE40 -> hsclk_sel=0 next edge; TO_SLOW; SLOW after ls_ack; hold counter=0.
REQ-042 cfg_wr 3'b101 in FAST -> cpuclk_div_sel stays 2'b00 until SLOW entry, then becomes 2'b01.
REQ-043 hs_ack never asserts -> err=1 after 255 cycles in TO_FAST; state SLOW; hsclk_sel=0.
REQ-044 Access at 24'hFFFD00 during TO_FAST -> TO_SLOW next edge; rst pulse mid-TO_SLOW -> SLOW with all outputs at reset values.
